// File: rtl/axi_sram_slave_if.sv
// AXI3 bus bundle between a CPU-side master and the SRAM responder.
// Only the fields the responder consumes or produces are carried here.
interface axi_sram_slave_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wid, wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wid, wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI3 responder backed by a word-addressed SRAM; independent read and write
// engines handle INCR/FIXED bursts up to 16 beats with byte strobes.
module axi_sram_slave #(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input logic            i_clk,
  input logic            i_rst,
  axi_sram_slave_if.slave io_axi
);

  typedef enum logic {RIdle, RBurst} r_state_e;
  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;

  logic [31:0] r_mem [2**ADDR_WIDTH];

  // Holds the address channels closed until the first clock after reset release.
  logic r_en;

  r_state_e    r_rstate, w_rstate_nxt;
  logic [3:0]  r_rid, w_rid_nxt;
  logic [31:0] r_raddr, w_raddr_nxt;
  logic [3:0]  r_rlen, w_rlen_nxt;
  logic [2:0]  r_rsize, w_rsize_nxt;
  logic [1:0]  r_rburst, w_rburst_nxt;
  logic [3:0]  r_rbeat, w_rbeat_nxt;

  w_state_e    r_wstate, w_wstate_nxt;
  logic [3:0]  r_bid, w_bid_nxt;
  logic [31:0] r_waddr, w_waddr_nxt;
  logic [3:0]  r_wlen, w_wlen_nxt;
  logic [2:0]  r_wsize, w_wsize_nxt;
  logic [1:0]  r_wburst, w_wburst_nxt;
  logic [3:0]  r_wbeat, w_wbeat_nxt;
  logic        r_werr, w_werr_nxt;

  logic        w_arready, w_rvalid, w_rlast;
  logic [31:0] w_rdata;
  logic [1:0]  w_rresp;
  logic        w_awready, w_wready, w_bvalid, w_mem_we;
  logic [1:0]  w_bresp;

  logic        w_rbad, w_wbad;
  logic [31:0] w_raddr_adv, w_waddr_adv;
  logic [ADDR_WIDTH-1:0] w_ridx, w_widx;

  assign w_rbad      = r_rburst[1] || (r_rsize > 3'd2);
  assign w_wbad      = r_wburst[1] || (r_wsize > 3'd2);
  assign w_raddr_adv = (r_rburst == 2'b01) ? r_raddr + (32'd1 << r_rsize) : r_raddr;
  assign w_waddr_adv = (r_wburst == 2'b01) ? r_waddr + (32'd1 << r_wsize) : r_waddr;
  assign w_ridx      = r_raddr[ADDR_WIDTH+1:2];
  assign w_widx      = r_waddr[ADDR_WIDTH+1:2];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_en     <= 1'b0;
      r_rstate <= RIdle;
      r_rid    <= '0;
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rsize  <= '0;
      r_rburst <= '0;
      r_rbeat  <= '0;
      r_wstate <= WIdle;
      r_bid    <= '0;
      r_waddr  <= '0;
      r_wlen   <= '0;
      r_wsize  <= '0;
      r_wburst <= '0;
      r_wbeat  <= '0;
      r_werr   <= 1'b0;
    end else begin
      r_en     <= 1'b1;
      r_rstate <= w_rstate_nxt;
      r_rid    <= w_rid_nxt;
      r_raddr  <= w_raddr_nxt;
      r_rlen   <= w_rlen_nxt;
      r_rsize  <= w_rsize_nxt;
      r_rburst <= w_rburst_nxt;
      r_rbeat  <= w_rbeat_nxt;
      r_wstate <= w_wstate_nxt;
      r_bid    <= w_bid_nxt;
      r_waddr  <= w_waddr_nxt;
      r_wlen   <= w_wlen_nxt;
      r_wsize  <= w_wsize_nxt;
      r_wburst <= w_wburst_nxt;
      r_wbeat  <= w_wbeat_nxt;
      r_werr   <= w_werr_nxt;
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_rid_nxt    = r_rid;
    w_raddr_nxt  = r_raddr;
    w_rlen_nxt   = r_rlen;
    w_rsize_nxt  = r_rsize;
    w_rburst_nxt = r_rburst;
    w_rbeat_nxt  = r_rbeat;
    w_arready    = 1'b0;
    w_rvalid     = 1'b0;
    w_rdata      = '0;
    w_rresp      = 2'b00;
    w_rlast      = 1'b0;
    unique case (r_rstate)
      RIdle: begin
        w_arready = r_en;
        if (io_axi.arvalid && r_en) begin
          w_rid_nxt    = io_axi.arid;
          w_raddr_nxt  = io_axi.araddr;
          w_rlen_nxt   = io_axi.arlen[3:0];
          w_rsize_nxt  = io_axi.arsize;
          w_rburst_nxt = io_axi.arburst;
          w_rbeat_nxt  = '0;
          w_rstate_nxt = RBurst;
        end
      end
      RBurst: begin
        w_rvalid = 1'b1;
        w_rdata  = w_rbad ? 32'h0 : r_mem[w_ridx];
        w_rresp  = w_rbad ? 2'b10 : 2'b00;
        w_rlast  = (r_rbeat == r_rlen);
        if (io_axi.rready) begin
          if (r_rbeat == r_rlen) begin
            w_rstate_nxt = RIdle;
          end else begin
            w_rbeat_nxt = r_rbeat + 4'd1;
            w_raddr_nxt = w_raddr_adv;
          end
        end
      end
      default: w_rstate_nxt = RIdle;
    endcase
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_bid_nxt    = r_bid;
    w_waddr_nxt  = r_waddr;
    w_wlen_nxt   = r_wlen;
    w_wsize_nxt  = r_wsize;
    w_wburst_nxt = r_wburst;
    w_wbeat_nxt  = r_wbeat;
    w_werr_nxt   = r_werr;
    w_awready    = 1'b0;
    w_wready     = 1'b0;
    w_bvalid     = 1'b0;
    w_bresp      = 2'b00;
    w_mem_we     = 1'b0;
    unique case (r_wstate)
      WIdle: begin
        w_awready = r_en;
        if (io_axi.awvalid && r_en) begin
          w_bid_nxt    = io_axi.awid;
          w_waddr_nxt  = io_axi.awaddr;
          w_wlen_nxt   = io_axi.awlen[3:0];
          w_wsize_nxt  = io_axi.awsize;
          w_wburst_nxt = io_axi.awburst;
          w_wbeat_nxt  = '0;
          w_werr_nxt   = 1'b0;
          w_wstate_nxt = WData;
        end
      end
      WData: begin
        w_wready = 1'b1;
        if (io_axi.wvalid) begin
          w_mem_we = !w_wbad;
          if (io_axi.wlast != (r_wbeat == r_wlen)) w_werr_nxt = 1'b1;
          if (r_wbeat == r_wlen) begin
            w_wstate_nxt = WResp;
          end else begin
            w_wbeat_nxt = r_wbeat + 4'd1;
            w_waddr_nxt = w_waddr_adv;
          end
        end
      end
      WResp: begin
        w_bvalid = 1'b1;
        w_bresp  = (r_werr || w_wbad) ? 2'b10 : 2'b00;
        if (io_axi.bready) w_wstate_nxt = WIdle;
      end
      default: w_wstate_nxt = WIdle;
    endcase
  end

  // No reset: contents survive a reset, including beats written mid-burst.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (io_axi.wstrb[i]) r_mem[w_widx][8*i +: 8] <= io_axi.wdata[8*i +: 8];
      end
    end
  end

  assign io_axi.arready = w_arready;
  assign io_axi.rvalid  = w_rvalid;
  assign io_axi.rid     = r_rid;
  assign io_axi.rdata   = w_rdata;
  assign io_axi.rresp   = w_rresp;
  assign io_axi.rlast   = w_rlast;
  assign io_axi.awready = w_awready;
  assign io_axi.wready  = w_wready;
  assign io_axi.bvalid  = w_bvalid;
  assign io_axi.bid     = r_bid;
  assign io_axi.bresp   = w_bresp;

  logic w_unused;
  assign w_unused = ^{io_axi.wid, io_axi.arlen[7:4], io_axi.awlen[7:4]};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: a word-array model predicts every R and B
// beat, and a negedge monitor compares the DUT against those predictions.
module tb_axi_sram_slave;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rexp_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_sram_slave_if axi ();

  axi_sram_slave #(.ADDR_WIDTH(12)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_axi (axi)
  );

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] m_mem [4096];
  rexp_t rq[$];
  bexp_t bq[$];
  logic [31:0] g_wdata [16];
  logic [3:0]  g_wstrb [16];

  bit rr_mode = 1'b0;
  int rr_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] adv(input logic [31:0] a, input logic [2:0] s,
                                      input logic [1:0] b);
    return (b == 2'b01) ? a + (32'd1 << s) : a;
  endfunction

  // rready pattern 1,0,0 repeating when backpressure is enabled.
  always @(posedge clk) begin
    #1;
    axi.rready = rr_mode ? (rr_cnt % 3 == 0) : 1'b1;
    rr_cnt = rr_cnt + 1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (axi.rvalid) begin
        if (rq.size() == 0) begin
          chk("r_unexpected", {31'd0, axi.rvalid}, 32'd0);
        end else begin
          chk("rdata", axi.rdata, rq[0].data);
          chk("rid", {28'd0, axi.rid}, {28'd0, rq[0].id});
          chk("rresp", {30'd0, axi.rresp}, {30'd0, rq[0].resp});
          chk("rlast", {31'd0, axi.rlast}, {31'd0, rq[0].last});
          if (axi.rready) void'(rq.pop_front());
        end
      end
      if (axi.bvalid) begin
        if (bq.size() == 0) begin
          chk("b_unexpected", {31'd0, axi.bvalid}, 32'd0);
        end else begin
          chk("bid", {28'd0, axi.bid}, {28'd0, bq[0].id});
          chk("bresp", {30'd0, axi.bresp}, {30'd0, bq[0].resp});
          if (axi.bready) void'(bq.pop_front());
        end
      end
    end
  end

  // ch: 0=AW, 1=W, 2=AR. Returns #1 after the handshake edge.
  task automatic hs(input int ch);
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      case (ch)
        0: done = axi.awvalid && axi.awready;
        1: done = axi.wvalid && axi.wready;
        default: done = axi.arvalid && axi.arready;
      endcase
      @(posedge clk);
      #1;
    end
    if (!done) chk("handshake_timeout", ch, 32'hFFFF_FFFF);
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int lastbeat);
    logic [31:0] a = addr;
    bit err = 1'b0;
    bit bad = burst[1] || (size > 3'd2);
    @(posedge clk);
    #1;
    axi.awid = id; axi.awaddr = addr; axi.awlen = {4'd0, len};
    axi.awsize = size; axi.awburst = burst; axi.awvalid = 1'b1;
    hs(0);
    axi.awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      axi.wvalid = 1'b1; axi.wdata = g_wdata[b]; axi.wstrb = g_wstrb[b];
      axi.wlast = (b == lastbeat); axi.wid = id;
      hs(1);
      if (!bad) begin
        for (int i = 0; i < 4; i++)
          if (g_wstrb[b][i]) m_mem[a[13:2]][8*i +: 8] = g_wdata[b][8*i +: 8];
      end
      if ((b == lastbeat) != (b == int'(len))) err = 1'b1;
      a = adv(a, size, burst);
    end
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
    bq.push_back('{id: id, resp: (err || bad) ? 2'b10 : 2'b00});
  endtask

  task automatic ar_issue(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a = addr;
    bit bad = burst[1] || (size > 3'd2);
    @(posedge clk);
    #1;
    axi.arid = id; axi.araddr = addr; axi.arlen = {4'd0, len};
    axi.arsize = size; axi.arburst = burst; axi.arvalid = 1'b1;
    hs(2);
    axi.arvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      rq.push_back('{id: id, data: bad ? 32'h0 : m_mem[a[13:2]], resp: bad ? 2'b10 : 2'b00,
                     last: (b == int'(len))});
      a = adv(a, size, burst);
    end
  endtask

  task automatic rdrain();
    for (int i = 0; i < 300 && rq.size() != 0; i++) @(posedge clk);
    if (rq.size() != 0) begin
      chk("r_drain_timeout", rq.size(), 0);
      rq.delete();
    end
    #1;
  endtask

  task automatic bdrain();
    for (int i = 0; i < 300 && bq.size() != 0; i++) @(posedge clk);
    if (bq.size() != 0) begin
      chk("b_drain_timeout", bq.size(), 0);
      bq.delete();
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) m_mem[i] = 32'h0;
    axi.arvalid = 1'b0; axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b1;
    axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0;
    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
    axi.wid = '0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0;

    // Reset values.
    #2;
    chk("rst_arready", {31'd0, axi.arready}, 0);
    chk("rst_awready", {31'd0, axi.awready}, 0);
    chk("rst_rvalid", {31'd0, axi.rvalid}, 0);
    chk("rst_wready", {31'd0, axi.wready}, 0);
    chk("rst_bvalid", {31'd0, axi.bvalid}, 0);
    chk("rst_rlast", {31'd0, axi.rlast}, 0);
    chk("rst_rdata", axi.rdata, 0);
    chk("rst_ids", {24'd0, axi.rid, axi.bid}, 0);
    chk("rst_resps", {28'd0, axi.rresp, axi.bresp}, 0);
    #21 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_arready", {31'd0, axi.arready}, 1);
    chk("post_rst_awready", {31'd0, axi.awready}, 1);

    // Single beat write then read.
    g_wdata[0] = 32'hDEADBEEF; g_wstrb[0] = 4'hF;
    do_write(4'd1, 32'h40, 4'd0, 3'd2, 2'b01, 0);
    bdrain();
    ar_issue(4'd3, 32'h40, 4'd0, 3'd2, 2'b01);
    chk("single_rvalid_t1", {31'd0, axi.rvalid}, 1);
    chk("single_rdata", axi.rdata, 32'hDEADBEEF);
    chk("single_rid", {28'd0, axi.rid}, 3);
    chk("single_rlast", {31'd0, axi.rlast}, 1);
    rdrain();

    // INCR 4-beat write and readback.
    for (int i = 0; i < 4; i++) begin g_wdata[i] = i + 1; g_wstrb[i] = 4'hF; end
    do_write(4'd5, 32'h100, 4'd3, 3'd2, 2'b01, 3);
    bdrain();
    chk("model_incr_w0", m_mem[64], 32'd1);
    chk("model_incr_w3", m_mem[67], 32'd4);
    ar_issue(4'd6, 32'h100, 4'd3, 3'd2, 2'b01);
    rdrain();

    // FIXED burst with partial strobes onto a zeroed word.
    g_wdata[0] = 32'h0; g_wstrb[0] = 4'hF;
    do_write(4'd2, 32'h20, 4'd0, 3'd2, 2'b01, 0);
    bdrain();
    g_wdata[0] = 32'h11111111; g_wstrb[0] = 4'h1;
    g_wdata[1] = 32'h22222222; g_wstrb[1] = 4'h4;
    do_write(4'd4, 32'h20, 4'd1, 3'd2, 2'b00, 1);
    bdrain();
    chk("model_fixed", m_mem[8], 32'h00220011);
    ar_issue(4'd4, 32'h20, 4'd0, 3'd2, 2'b01);
    rdrain();

    // Read backpressure; the monitor checks stability on stalled beats.
    rr_mode = 1'b1;
    ar_issue(4'd9, 32'h100, 4'd3, 3'd2, 2'b01);
    rdrain();
    rr_mode = 1'b0;

    // bready held low: B stays pending and AW stays closed.
    axi.bready = 1'b0;
    g_wdata[0] = 32'h55; g_wstrb[0] = 4'hF;
    do_write(4'd7, 32'h44, 4'd0, 3'd2, 2'b01, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bstall_bvalid", {31'd0, axi.bvalid}, 1);
      chk("bstall_awready", {31'd0, axi.awready}, 0);
    end
    @(posedge clk);
    #1;
    axi.bready = 1'b1;
    bdrain();

    // Error cases.
    ar_issue(4'd2, 32'h100, 4'd1, 3'd2, 2'b10);
    rdrain();
    for (int i = 0; i < 4; i++) begin g_wdata[i] = 32'hA5 + i; g_wstrb[i] = 4'hF; end
    do_write(4'd8, 32'h200, 4'd3, 3'd2, 2'b01, 1);
    chk("early_wlast_bresp", {30'd0, axi.bresp}, 2);
    bdrain();
    g_wdata[0] = 32'hCAFEF00D; g_wstrb[0] = 4'hF;
    do_write(4'd1, 32'h300, 4'd0, 3'd2, 2'b01, 0);
    bdrain();
    g_wdata[0] = 32'h12345678; g_wdata[1] = 32'h9ABCDEF0;
    g_wstrb[0] = 4'hF; g_wstrb[1] = 4'hF;
    do_write(4'd3, 32'h300, 4'd1, 3'd2, 2'b10, 1);
    bdrain();
    chk("model_wrap_unchanged", m_mem[192], 32'hCAFEF00D);
    ar_issue(4'd5, 32'h300, 4'd0, 3'd2, 2'b01);
    rdrain();

    // 16-beat read overlapped with a 16-beat write to a disjoint region.
    for (int i = 0; i < 16; i++) begin g_wdata[i] = 32'hA000_0000 + i; g_wstrb[i] = 4'hF; end
    do_write(4'd10, 32'h400, 4'd15, 3'd2, 2'b01, 15);
    bdrain();
    for (int i = 0; i < 16; i++) g_wdata[i] = 32'hB000_0000 + 32'(i * 3);
    fork
      begin ar_issue(4'd11, 32'h400, 4'd15, 3'd2, 2'b01); rdrain(); end
      begin do_write(4'd12, 32'h800, 4'd15, 3'd2, 2'b01, 15); bdrain(); end
    join
    ar_issue(4'd13, 32'h800, 4'd15, 3'd2, 2'b01);
    rdrain();

    // Reset during the second beat of a read.
    ar_issue(4'd14, 32'h400, 4'd3, 3'd2, 2'b01);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_rvalid", {31'd0, axi.rvalid}, 0);
    chk("midrst_arready", {31'd0, axi.arready}, 0);
    chk("midrst_rdata", axi.rdata, 0);
    rq.delete();
    bq.delete();
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("release_arready", {31'd0, axi.arready}, 1);
    chk("release_rvalid", {31'd0, axi.rvalid}, 0);
    ar_issue(4'd15, 32'h408, 4'd1, 3'd2, 2'b01);
    rdrain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
